// File: rtl/uart_rx_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_word_fifo
// Brief    : Packs UART bytes into 32-bit little-endian words and queues them
//            in a first-word-fall-through FIFO with valid/ready drain.
//            Optional feature macro: UART_RX_FERR_DROP_EN (drop framing-error
//            bytes and abandon the partial word).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rdata,
    input  logic                  rdata_ready,
    input  logic                  ferr,
    input  logic                  clear,
    output logic [31:0]           word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [1:0]            byte_phase
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_full_count = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one    = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   c_cnt_one    = (DEPTH_LOG2+1)'(1);

    logic [1:0]            phase_q, phase_d;
    logic [7:0]            lane0_q, lane0_d, lane1_q, lane1_d, lane2_q, lane2_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           mem_q [0:DEPTH-1];

    logic        w_accept, w_push, w_pop, w_full, w_wr_en;
    logic [31:0] w_word;

`ifdef UART_RX_FERR_DROP_EN
    assign w_accept = rdata_ready && !ferr;
`else
    logic w_ferr_unused;
    assign w_ferr_unused = ferr;
    assign w_accept      = rdata_ready;
`endif

    assign w_push  = w_accept && (phase_q == 2'd3);
    assign w_pop   = (count_q != '0) && word_ready;
    assign w_full  = (count_q == c_full_count);
    // A full FIFO still takes the word when a pop frees a slot in the same cycle.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_word  = {rdata, lane2_q, lane1_q, lane0_q};

    always_comb begin
        phase_d  = phase_q;
        lane0_d  = lane0_q;
        lane1_d  = lane1_q;
        lane2_d  = lane2_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (w_accept) begin
            phase_d = phase_q + 2'd1;
            case (phase_q)
                2'd0:    lane0_d = rdata;
                2'd1:    lane1_d = rdata;
                2'd2:    lane2_d = rdata;
                default: ;
            endcase
        end
`ifdef UART_RX_FERR_DROP_EN
        if (rdata_ready && ferr) begin
            phase_d = 2'd0;
        end
`endif

        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_push && !w_wr_en) begin
            ovf_d = 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end

        case ({w_wr_en, w_pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            phase_q  <= 2'd0;
            lane0_q  <= 8'd0;
            lane1_q  <= 8'd0;
            lane2_q  <= 8'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            lane0_q  <= lane0_d;
            lane1_q  <= lane1_d;
            lane2_q  <= lane2_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array carries no reset; pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst && !clear) begin
            mem_q[wr_ptr_q] <= w_word;
        end
    end

    assign word_valid = (count_q != '0);
    assign word_out   = word_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign byte_phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_word_fifo
// Brief    : Scoreboard bench for uart_rx_word_fifo; drained words are
//            compared by a monitor against an expected-word queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word_fifo;

    localparam int DEPTH_LOG2 = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          rdata = 8'd0;
    logic                rdata_ready = 1'b0;
    logic                ferr = 1'b0;
    logic                clear = 1'b0;
    logic [31:0]         word_out;
    logic                word_valid;
    logic                word_ready = 1'b0;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic [1:0]          byte_phase;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb [$];

    uart_rx_word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdata       (rdata),
        .rdata_ready (rdata_ready),
        .ferr        (ferr),
        .clear       (clear),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .count       (count),
        .overflow    (overflow),
        .byte_phase  (byte_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (!word_valid) begin
                chk("word_out_masked", word_out, 32'd0);
            end else if (word_ready) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_word: got 0x%08h expected none", word_out);
                end else begin
                    chk("drain_word", word_out, sb.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the strobe was sampled.
    task automatic strobe(input logic [7:0] b, input logic fe);
        rdata       = b;
        rdata_ready = 1'b1;
        ferr        = fe;
        @(posedge clk); #1;
        rdata_ready = 1'b0;
        ferr        = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stored);
        strobe(w[7:0], 1'b0);
        strobe(w[15:8], 1'b0);
        strobe(w[23:16], 1'b0);
        strobe(w[31:24], 1'b0);
        if (stored) sb.push_back(w);
    endtask

    task automatic drain();
        int n = 0;
        word_ready = 1'b1;
        while (word_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        word_ready = 1'b0;
        chk("drain_done_valid", {31'd0, word_valid}, 32'd0);
        chk("drain_sb_empty", sb.size(), 32'd0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        logic [7:0] k8;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_word", word_out, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_phase", 32'(byte_phase), 32'd0);

        // Basic word, visible one cycle after the 4th strobe
        strobe(8'h78, 1'b0);
        strobe(8'h56, 1'b0);
        strobe(8'h34, 1'b0);
        strobe(8'h12, 1'b0);
        sb.push_back(32'h12345678);
        chk("basic_valid", {31'd0, word_valid}, 32'd1);
        chk("basic_word", word_out, 32'h12345678);
        chk("basic_count", 32'(count), 32'd1);
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        chk("basic_pop_valid", {31'd0, word_valid}, 32'd0);
        chk("basic_pop_count", 32'(count), 32'd0);

        // Fill to 16 then overflow with a 17th word
        for (int k = 0; k < 17; k++) begin
            k8 = 8'(k);
            send_word({4{k8}}, k < 16);
        end
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_overflow", {31'd0, overflow}, 32'd1);
        drain();
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);
        pulse_clear();
        chk("clear_overflow", {31'd0, overflow}, 32'd0);

        // Full with simultaneous pop: the 17th word is accepted
        for (int k = 0; k < 16; k++) begin
            k8 = 8'(8'h20 + k);
            send_word({4{k8}}, 1'b1);
        end
        chk("full2_count", 32'(count), 32'd16);
        strobe(8'hC1, 1'b0);
        strobe(8'hC2, 1'b0);
        strobe(8'hC3, 1'b0);
        word_ready = 1'b1;
        strobe(8'hC4, 1'b0);
        sb.push_back(32'hC4C3C2C1);
        chk("full_pop_count", 32'(count), 32'd16);
        chk("full_pop_overflow", {31'd0, overflow}, 32'd0);
        drain();

        // Clear coincident with a 3rd byte strobe
        strobe(8'h11, 1'b0);
        strobe(8'h22, 1'b0);
        rdata       = 8'h33;
        rdata_ready = 1'b1;
        clear       = 1'b1;
        @(posedge clk); #1;
        rdata_ready = 1'b0;
        clear       = 1'b0;
        chk("clear_phase", 32'(byte_phase), 32'd0);
        chk("clear_count", 32'(count), 32'd0);
        send_word(32'hDDCCBBAA, 1'b1);
        chk("after_clear_count", 32'(count), 32'd1);
        drain();

        // Framing error in the second byte
        strobe(8'h01, 1'b0);
        strobe(8'h02, 1'b1);
        strobe(8'h03, 1'b0);
        strobe(8'h04, 1'b0);
        strobe(8'h05, 1'b0);
`ifdef UART_RX_FERR_DROP_EN
        chk("ferr_phase", 32'(byte_phase), 32'd3);
        chk("ferr_count", 32'(count), 32'd0);
`else
        sb.push_back(32'h04030201);
        chk("ferr_phase", 32'(byte_phase), 32'd1);
        chk("ferr_count", 32'(count), 32'd1);
        drain();
`endif

        // Reset mid-word returns everything to idle
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2_phase", 32'(byte_phase), 32'd0);
        chk("rst2_count", 32'(count), 32'd0);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_word_fifo.md
# uart_rx_word_fifo

Byte-to-word receive buffer directly downstream of the UART receiver. Packs each group of four received bytes into one 32-bit little-endian word and queues it in a first-word-fall-through FIFO. The core or the program loader drains the FIFO through a valid/ready handshake. The block gives the core a word-granular input stream (instruction upload, `in` instruction data) that tolerates bursty UART arrival and slow consumers.

## Interface
- `DEPTH_LOG2`, default 4: FIFO holds 2**DEPTH_LOG2 words.
- `clk` in, 1: system clock; same clock as the UART receiver.
- `rst` in, 1: synchronous, active-high reset.
- `rdata` in, 8: received byte; valid only while `rdata_ready`=1.
- `rdata_ready` in, 1: one-cycle strobe, one per received byte.
- `ferr` in, 1: framing-error strobe, coincident with `rdata_ready`.
- `clear` in, 1: synchronous flush of the partial word, the FIFO and `overflow`.
- `word_out` out, 32: FIFO head word; 0 whenever `word_valid`=0.
- `word_valid` out, 1: FIFO non-empty.
- `word_ready` in, 1: consumer accepts the head word this cycle.
- `count` out, DEPTH_LOG2+1: number of words stored, 0..2**DEPTH_LOG2.
- `overflow` out, 1: sticky; a completed word was dropped because the FIFO was full.
- `byte_phase` out, 2: number of bytes held in the partial word, 0..3.

## Operation
- Reset (`rst`=1) or `clear`=1 at an edge sets the following. This has priority over any byte strobe or pop in the same cycle.
  - `byte_phase`=0
  - read/write pointers=0
  - `count`=0
  - `overflow`=0
- Outputs after reset: `word_valid`=0, `word_out`=0.
- Assembler:
  - On `rdata_ready`, write `rdata` into lane `byte_phase` (bits [8*p+7:8*p]) and advance `byte_phase` modulo 4.
  - On the byte with `byte_phase`=3, form the word {rdata, lanes 2..0} and issue a push.
- Push:
  - Writes mem[wr_ptr] and increments wr_ptr (wraps at 2**DEPTH_LOG2).
  - If `count`=2**DEPTH_LOG2 and no pop occurs that cycle, the word is discarded, `overflow`<=1, and pointers are unchanged. The assembler still returns to phase 0.
- Pop: occurs when `word_valid`&&`word_ready`. Increments rd_ptr (wraps). `word_ready` while empty has no effect.
- Simultaneous push and pop:
  - Both happen and `count` is unchanged.
  - This includes the full case, so a push into a full FIFO with a concurrent pop is accepted.
  - When empty, the pop is ignored and the push happens.
- `count` is updated as +1 on push only, -1 on pop only, and is never outside 0..2**DEPTH_LOG2.
- `word_out` = mem[rd_ptr] (asynchronous read) masked by `word_valid`.

## Timing
- Byte strobe at edge t updates lane/phase at edge t.
- A 4th-byte strobe sampled at edge t writes the FIFO at edge t. `word_valid`=1 and `word_out` are valid in the cycle after edge t, so latency from the 4th byte strobe to visible word is 1 cycle.
- Pop sampled at edge t: the next head (or `word_valid`=0) appears after edge t.
- Back-to-back pops every cycle are supported. Byte strobes arrive at most once per UART bit period, but every-cycle strobes must also be handled correctly.
- `overflow`, `count` and `byte_phase` are registered and change only at edges.

## Configuration
- `UART_RX_FERR_DROP_EN` defined:
  - A strobe with `ferr`=1 discards that byte and resets `byte_phase` to 0, abandoning the partial word.
  - No push results from it.
- Not defined: `ferr` is ignored, and the byte is assembled like any other.

## Test plan
- Reset: after `rst`, `word_valid`=0, `word_out`=0, `count`=0, `overflow`=0, `byte_phase`=0.
- Basic word, with `word_ready`=0:
  - Stimulus: bytes 0x78, 0x56, 0x34, 0x12.
  - Response: `word_valid`=1 one cycle after the 4th strobe, `word_out`=0x12345678, `count`=1.
  - Then pulse `word_ready` once; `word_valid`=0 and `count`=0 next cycle.
- Fill and overflow, with DEPTH_LOG2=4:
  - Stimulus: push 17 words (word k = {4{k[7:0]}}) with no pops.
  - Response: `count`=16, `overflow`=1, drain order 0x00000000..0x0F0F0F0F.
- Full with simultaneous pop:
  - Stimulus: with 16 words stored, complete the 17th word on the same cycle as `word_ready`=1.
  - Response: `count` stays 16, `overflow`=0, last drained word is the 17th.
- Clear mid-word: after 2 bytes, assert `clear` together with a 3rd `rdata_ready`. Next cycle `byte_phase`=0 and `count`=0. The next 4 bytes 0xAA, 0xBB, 0xCC, 0xDD yield 0xDDCCBBAA.
- Framing error: bytes 0x01, 0x02 (with `ferr`=1), 0x03, 0x04, 0x05.
  - With `UART_RX_FERR_DROP_EN`: no word after 0x05 (`byte_phase`=3).
  - Without it: word 0x04030201 is produced and `byte_phase`=1.
